// File: rtl/program_loader.sv
// program_loader: byte-stream writer that fills main memory with a program image
// while the core is held in reset, then releases the core once the image is in place.
// Stream: 4-byte little-endian word count N, then N little-endian 32-bit words.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (CHK state) that must match the XOR of all header and data bytes.
module program_loader #(
   parameter int unsigned DEPTH     = 2048,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        reload,
   output logic [31:0] write_address,
   output logic [31:0] write_data,
   output logic        write_enable,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;
`endif

   state_t              state;
   logic [1:0]          byte_idx;
   logic [WORD_W-1:0]   count;
   logic [WORD_W-1:0]   word_cnt;
   logic [WORD_W-1:0]   buffer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]   csum;
`endif

   logic                accept_c;
   logic [4:0]          lane_c;
   logic [WORD_W-1:0]   hdr_full_c;
   logic [WORD_W-1:0]   word_full_c;
   logic                last_word_c;

   // Handshake, byte lane position and fully-assembled header/word values
   always_comb begin
      accept_c    = in_valid && in_ready;
      lane_c      = {byte_idx, 3'b000};
      hdr_full_c  = {in_data, count[23:0]};
      word_full_c = {in_data, buffer[23:0]};
      last_word_c = (word_cnt + 32'd1) == count;
   end

   // Loader state machine with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_HDR;
         in_ready      <= 1'b1;
         write_enable  <= 1'b0;
         write_address <= WORD_W'(BASE_ADDR);
         write_data    <= '0;
         cpu_hold      <= 1'b1;
         done          <= 1'b0;
         error         <= 1'b0;
         byte_idx      <= 2'd0;
         word_cnt      <= '0;
         count         <= '0;
         buffer        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum          <= '0;
`endif
      end else begin
         case (state)
            S_HDR: begin
               if (accept_c) begin
                  count[lane_c +: BYTE_W] <= in_data;
                  byte_idx <= byte_idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum <= csum ^ in_data;
`endif
                  if (byte_idx == 2'd3) begin
                     if (hdr_full_c == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        in_ready <= 1'b0;
`endif
                     end else if (hdr_full_c > WORD_W'(DEPTH)) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        cpu_hold <= 1'b1;
                        in_ready <= 1'b0;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
            end

            S_DATA: begin
               if (accept_c) begin
                  buffer[lane_c +: BYTE_W] <= in_data;
                  byte_idx <= byte_idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum <= csum ^ in_data;
`endif
                  if (byte_idx == 2'd3) begin
                     state         <= S_WRITE;
                     in_ready      <= 1'b0;
                     write_enable  <= 1'b1;
                     write_address <= WORD_W'(BASE_ADDR) + word_cnt;
                     write_data    <= word_full_c;
                  end
               end
            end

            S_WRITE: begin
               write_enable <= 1'b0;
               word_cnt     <= word_cnt + 32'd1;
               if (last_word_c) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state    <= S_CHK;
                  in_ready <= 1'b1;
`else
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  state    <= S_DATA;
                  in_ready <= 1'b1;
               end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (accept_c) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state    <= S_ERR;
                     error    <= 1'b1;
                     cpu_hold <= 1'b1;
                  end
               end
            end
`endif

            S_DONE, S_ERR: begin
               if (reload) begin
                  state    <= S_HDR;
                  in_ready <= 1'b1;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  byte_idx <= 2'd0;
                  word_cnt <= '0;
                  count    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end

            default: begin
               state    <= S_HDR;
               in_ready <= 1'b1;
               byte_idx <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, stalled load, oversize header,
// DEPTH boundary, reset mid-load, reload with empty image and (optionally) checksum.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        reload;
   logic [31:0] write_address;
   logic [31:0] write_data;
   logic        write_enable;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic        prev_we = 1'b0;
   logic        back_to_back = 1'b0;
   logic [7:0]  run_xor = 8'h00;

   program_loader dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .reload        (reload),
      .write_address (write_address),
      .write_data    (write_data),
      .write_enable  (write_enable),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   // Record every memory write and flag back-to-back strobes
   always @(negedge clk) begin
      if (write_enable) begin
         wr_addr_q.push_back(write_address);
         wr_data_q.push_back(write_data);
      end
      if (write_enable && prev_we) back_to_back = 1'b1;
      prev_we = write_enable;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one byte at a negedge, hold until accepted; optional idle cycle after
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
      @(negedge clk);
      run_xor  = run_xor ^ b;
      in_valid = 1'b0;
      if (gap) @(negedge clk);
   endtask

   task automatic send_trailer(input logic [7:0] flip);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(run_xor ^ flip, 1'b0);
`endif
   endtask

   task automatic send_img1(input bit gap);
      logic [7:0] img[12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                              8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_xor = 8'h00;
      foreach (img[i]) send_byte(img[i], gap);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      back_to_back = 1'b0;
   endtask

   task automatic check_img1(input string tag);
      chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() == 2) begin
         chk({tag, "_addr0"}, wr_addr_q[0], 32'd0);
         chk({tag, "_data0"}, wr_data_q[0], 32'h12345678);
         chk({tag, "_addr1"}, wr_addr_q[1], 32'd1);
         chk({tag, "_data1"}, wr_data_q[1], 32'hDEADBEEF);
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_addr", write_address, 32'd0);
      chk("rst_data", write_data, 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Test 1: two-word image back to back
      send_img1(1'b0);
      send_trailer(8'h00);
      repeat (3) @(negedge clk);
      check_img1("t1");
      chk("t1_b2b", 32'(back_to_back), 32'd0);

      // Test 2: same image with an idle cycle between bytes
      pulse_reload();
      chk("t2_reload_done", 32'(done), 32'd0);
      chk("t2_reload_hold", 32'(cpu_hold), 32'd1);
      chk("t2_reload_ready", 32'(in_ready), 32'd1);
      clear_log();
      send_img1(1'b1);
      send_trailer(8'h00);
      repeat (3) @(negedge clk);
      check_img1("t2");
      chk("t2_b2b", 32'(back_to_back), 32'd0);

      // Test 3: N = 2049 exceeds DEPTH
      pulse_reload();
      clear_log();
      run_xor = 8'h00;
      send_byte(8'h01, 1'b0);
      send_byte(8'h08, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      repeat (3) @(negedge clk);
      chk("t3_error", 32'(error), 32'd1);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("t3_done", 32'(done), 32'd0);
      chk("t3_nwrites", 32'(wr_addr_q.size()), 32'd0);

      // Boundary: N = DEPTH is accepted
      pulse_reload();
      chk("tb_reload_clears_err", 32'(error), 32'd0);
      run_xor = 8'h00;
      send_byte(8'h00, 1'b0);
      send_byte(8'h08, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("tb_depth_error", 32'(error), 32'd0);
      chk("tb_depth_ready", 32'(in_ready), 32'd1);

      // Test 4: reset mid-load after 6 data bytes, then fresh N=1 image
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      clear_log();
      run_xor = 8'h00;
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
      chk("t4_partial_nwrites", 32'(wr_addr_q.size()), 32'd1);
      if (wr_data_q.size() == 1) chk("t4_partial_data", wr_data_q[0], 32'h04030201);
      rst = 1'b0;
      @(negedge clk);
      chk("t4_rst_we", 32'(write_enable), 32'd0);
      chk("t4_rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      clear_log();
      run_xor = 8'h00;
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
      send_trailer(8'h00);
      repeat (3) @(negedge clk);
      chk("t4_nwrites", 32'(wr_addr_q.size()), 32'd1);
      if (wr_addr_q.size() == 1) begin
         chk("t4_addr", wr_addr_q[0], 32'd0);
         chk("t4_data", wr_data_q[0], 32'hDDCCBBAA);
      end
      chk("t4_done", 32'(done), 32'd1);

      // Test 5: reload from DONE with an empty image
      clear_log();
      pulse_reload();
      chk("t5_reload_done", 32'(done), 32'd0);
      chk("t5_reload_hold", 32'(cpu_hold), 32'd1);
      run_xor = 8'h00;
      repeat (4) send_byte(8'h00, 1'b0);
      send_trailer(8'h00);
      @(negedge clk);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("t5_nwrites", 32'(wr_addr_q.size()), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Test 6: checksum mismatch aborts the load
      pulse_reload();
      clear_log();
      send_img1(1'b0);
      send_trailer(8'h01);
      repeat (2) @(negedge clk);
      chk("t6_error", 32'(error), 32'd1);
      chk("t6_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("t6_done", 32'(done), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
